// File: rtl/dec_control.sv
// dec_control: cycle-count sequencer for the VAE decoder datapath.
//
// After a one-cycle start pulse in IDLE the block enters RUN and counts clock
// cycles. The dec1/dec2/dec3 stage holds are released (driven 0) in order at
// fixed counter values that cover each stage's MAC latency plus the latency of
// the activation that follows it. When the final sigmoid has had time to
// settle the block enters DONE, raises a sticky done_flag with a one-cycle
// done_pulse, and holds every stage running until the consumer acknowledges.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low; clears all state
//   start      in   begin decode (sampled only in IDLE)
//   ack        in   consumer acknowledge (sampled only in DONE)
//   abort      in   synchronous abort, highest priority, returns to IDLE
//   dec1_start out  dec1 hold: 1 = held in reset, 0 = running
//   dec2_start out  dec2 hold, same encoding
//   dec3_start out  dec3 hold, same encoding
//   busy       out  1 while in RUN
//   done_flag  out  1 while in DONE
//   done_pulse out  one-cycle pulse on DONE entry
//   debug_cc   out  current cycle counter value
module dec_control #(
  parameter int OFFSET  = 2,
  parameter int DEC1_CC = 8,
  parameter int ACT1    = 3,
  parameter int DEC2_CC = 12,
  parameter int ACT2    = 3,
  parameter int DEC3_CC = 8,
  parameter int SIGMOID = 3,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             abort,
  output logic             dec1_start,
  output logic             dec2_start,
  output logic             dec3_start,
  output logic             busy,
  output logic             done_flag,
  output logic             done_pulse,
  output logic [CNT_W-1:0] debug_cc
);

  // Release times, in counter values seen during RUN.
  localparam int T1 = OFFSET;
  localparam int T2 = T1 + DEC1_CC + ACT1;
  localparam int T3 = T2 + DEC2_CC + ACT2;
  localparam int TD = T3 + DEC3_CC + SIGMOID;

  // The release points must be strictly ordered and the counter must be able
  // to reach TD without wrapping.
  generate
    if (!(T1 < T2 && T2 < T3 && T3 < TD && TD < (1 << CNT_W))) begin : g_bad_timing
      $error("dec_control: release times must satisfy T1 < T2 < T3 < TD < 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] T1_CC = T1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] T2_CC = T2[CNT_W-1:0];
  localparam logic [CNT_W-1:0] T3_CC = T3[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TD_CC = TD[CNT_W-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cc         <= '0;
      dec1_start <= 1'b1;
      dec2_start <= 1'b1;
      dec3_start <= 1'b1;
      busy       <= 1'b0;
      done_flag  <= 1'b0;
      done_pulse <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cc         <= '0;
      dec1_start <= 1'b1;
      dec2_start <= 1'b1;
      dec3_start <= 1'b1;
      busy       <= 1'b0;
      done_flag  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The counter stays at 0 on the entry edge; the first RUN edge
          // compares cc==0, so dec1 falls at E0+T1+1.
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (cc == T1_CC) dec1_start <= 1'b0;
          if (cc == T2_CC) dec2_start <= 1'b0;
          if (cc == T3_CC) dec3_start <= 1'b0;
          if (cc == TD_CC) begin
            // Counter freezes at TD for the whole DONE phase.
            state      <= DONE;
            busy       <= 1'b0;
            done_flag  <= 1'b1;
            done_pulse <= 1'b1;
          end else begin
            cc <= cc + 1'b1;
          end
        end

        DONE: begin
          done_pulse <= 1'b0;
          // A start coinciding with ack is dropped, not remembered.
          if (ack) begin
            state      <= IDLE;
            cc         <= '0;
            dec1_start <= 1'b1;
            dec2_start <= 1'b1;
            dec3_start <= 1'b1;
            done_flag  <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          cc         <= '0;
          dec1_start <= 1'b1;
          dec2_start <= 1'b1;
          dec3_start <= 1'b1;
          busy       <= 1'b0;
          done_flag  <= 1'b0;
          done_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign debug_cc = cc;

endmodule

// File: tb/tb_dec_control.sv
// tb_dec_control: bench for dec_control. Drives a default instance and an
// instance with OFFSET=1, DEC2_CC=4 from the same inputs, and predicts both
// from a timing model: while active, every output is a function of the
// number of clock edges elapsed since the accepted start.
module tb_dec_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic       a_d1, a_d2, a_d3, a_busy, a_done, a_pulse;
  logic [6:0] a_cc;
  logic       b_d1, b_d2, b_d3, b_busy, b_done, b_pulse;
  logic [6:0] b_cc;

  dec_control u_def (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .abort(abort),
    .dec1_start(a_d1), .dec2_start(a_d2), .dec3_start(a_d3),
    .busy(a_busy), .done_flag(a_done), .done_pulse(a_pulse), .debug_cc(a_cc)
  );

  dec_control #(.OFFSET(1), .DEC2_CC(4)) u_ovr (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .abort(abort),
    .dec1_start(b_d1), .dec2_start(b_d2), .dec3_start(b_d3),
    .busy(b_busy), .done_flag(b_done), .done_pulse(b_pulse), .debug_cc(b_cc)
  );

  int total = 0;
  int bad   = 0;

  // Model: active[d]=0 means idle; otherwise j[d] = edges since the start edge.
  int active[2];
  int j[2];
  int t1[2], t2[2], t3[2], td[2];

  task automatic set_times(input int d, input int off, input int c1, input int a1,
                           input int c2, input int a2, input int c3, input int sg);
    t1[d] = off;
    t2[d] = t1[d] + c1 + a1;
    t3[d] = t2[d] + c2 + a2;
    td[d] = t3[d] + c3 + sg;
  endtask

  task automatic model_edge(input int d);
    if (!reset || abort) begin
      active[d] = 0;
    end else if (active[d] == 0) begin
      if (start) begin
        active[d] = 1;
        j[d] = 0;
      end
    end else if (j[d] >= td[d] + 1 && ack) begin
      active[d] = 0;
    end else if (j[d] < td[d] + 2) begin
      j[d] = j[d] + 1;
    end
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic d1, input logic d2, input logic d3,
                           input logic bz, input logic dn, input logic pl, input logic [6:0] cc);
    int k;
    string p;
    p = (d == 0) ? "def" : "ovr";
    if (active[d] == 0) begin
      check1({p, ".dec1_start"}, d1, 1);
      check1({p, ".dec2_start"}, d2, 1);
      check1({p, ".dec3_start"}, d3, 1);
      check1({p, ".busy"}, bz, 0);
      check1({p, ".done_flag"}, dn, 0);
      check1({p, ".done_pulse"}, pl, 0);
      check1({p, ".debug_cc"}, cc, 0);
    end else begin
      k = j[d];
      check1({p, ".dec1_start"}, d1, (k >= t1[d] + 1) ? 0 : 1);
      check1({p, ".dec2_start"}, d2, (k >= t2[d] + 1) ? 0 : 1);
      check1({p, ".dec3_start"}, d3, (k >= t3[d] + 1) ? 0 : 1);
      check1({p, ".busy"}, bz, (k <= td[d]) ? 1 : 0);
      check1({p, ".done_flag"}, dn, (k >= td[d] + 1) ? 1 : 0);
      check1({p, ".done_pulse"}, pl, (k == td[d] + 1) ? 1 : 0);
      check1({p, ".debug_cc"}, cc, (k < td[d]) ? k : td[d]);
    end
  endtask

  task automatic check_all();
    check_dut(0, a_d1, a_d2, a_d3, a_busy, a_done, a_pulse, a_cc);
    check_dut(1, b_d1, b_d2, b_d3, b_busy, b_done, b_pulse, b_cc);
  endtask

  // One clock: inputs are already set; model advances on the edge, outputs
  // are checked on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic apply_reset(input int n);
    reset = 1'b0;
    #1;
    active[0] = 0;
    active[1] = 0;
    check_all();
    cycles(n);
    reset = 1'b1;
  endtask

  initial begin
    set_times(0, 2, 8, 3, 12, 3, 8, 3);
    set_times(1, 1, 8, 3, 4, 3, 8, 3);
    active[0] = 0; active[1] = 0;
    j[0] = 0; j[1] = 0;

    // Power-up reset, then idle with no start.
    @(negedge clk);
    apply_reset(2);
    cycles(5);

    // Full sequence with a spurious start re-pulse during RUN.
    pulse_start();
    cycles(9);
    pulse_start();
    cycles(34);

    // start together with ack in DONE: back to IDLE, start not latched.
    start = 1'b1;
    ack = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b0;
    cycles(4);

    // Second run reproduces the timing, then plain ack.
    pulse_start();
    cycles(42);
    pulse_ack();
    cycles(2);

    // Abort mid-run, then a complete run afterwards.
    pulse_start();
    cycles(19);
    pulse_abort();
    cycles(45);
    pulse_start();
    cycles(42);
    pulse_ack();

    // Abort while in DONE.
    pulse_start();
    cycles(42);
    pulse_abort();
    cycles(3);

    // Reset mid-run; stays idle afterwards.
    pulse_start();
    cycles(29);
    apply_reset(2);
    cycles(5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) apply_reset(1 + $urandom_range(0, 2));
      tick();
    end
    start = 1'b0;
    ack = 1'b0;
    abort = 1'b0;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
